memory_access: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, directly downstream of `instruction_execute` and upstream of write-back. It performs data-memory loads and stores at byte, halfword and word width using the ALU result as the address. It sign- or zero-extends load data and registers everything into the MEM/WB pipeline register. It also exposes a combinational debug read port for the debug unit.

---
 rtl/memory_access_pkg.sv | 20 ++
 rtl/memory_access_data_memory.sv | 38 +++
 rtl/memory_access.sv | 132 +++++++++++++
 tb/tb_memory_access.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared MIPS constants for the memory stage and decode.
// Provides the load/store size encodings and an alignment helper.
package memory_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Encoding 2'b11 is reserved and behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_data_memory.sv
// data_memory: word-organised data RAM with per-byte write enables.
// Ports:
//   i_clk        - clock, writes on rising edge
//   i_byte_we    - per-byte write enable, bit b writes bits [8b+7:8b]
//   i_addr       - word address for the write and the main read port
//   i_wdata      - write data, already steered to its byte lanes
//   o_rdata      - asynchronous read of word i_addr
//   i_debug_addr - word address of the independent debug read port
//   o_debug_data - asynchronous read of word i_debug_addr
// Contents are not reset.
module data_memory #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned NB_ADDR   = $clog2(MEM_DEPTH)
) (
  input  logic               i_clk,
  input  logic [3:0]         i_byte_we,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic [NB_DATA-1:0] o_rdata,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data
);

  logic [NB_DATA-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_byte_we[b]) begin
        mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata      = mem[i_addr];
  assign o_debug_data = mem[i_debug_addr];

endmodule

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage MIPS pipeline.
// Performs byte/half/word loads and stores at address i_ALU_result, extends
// load data and registers the results into the MEM/WB pipeline register.
// Ports:
//   i_clk, i_reset (sync, active-low), i_enable (pipeline advance)
//   i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write - EX/MEM control
//   i_mem_size, i_mem_unsigned - access width and load extension
//   i_write_reg, i_ALU_result, i_data_to_write_in_MEM - EX/MEM data
//   i_debug_addr / o_debug_data - combinational debug word read
//   o_WB_write, o_WB_mem_to_reg, o_write_reg, o_mem_data, o_ALU_result,
//   o_misaligned - registered MEM/WB outputs
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned NB_ADDR   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic [1:0]         i_mem_size,
  input  logic               i_mem_unsigned,
  input  logic [4:0]         i_write_reg,
  input  logic [NB_DATA-1:0] i_ALU_result,
  input  logic [NB_DATA-1:0] i_data_to_write_in_MEM,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic [4:0]         o_write_reg,
  output logic [NB_DATA-1:0] o_mem_data,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic               o_misaligned,
  output logic [NB_DATA-1:0] o_debug_data
);

  logic [NB_ADDR-1:0] word_addr;
  logic [1:0]         offset;
  logic               misaligned;
  logic [3:0]         byte_we;
  logic [NB_DATA-1:0] wdata;
  logic [NB_DATA-1:0] rdata;
  logic [7:0]         byte_lane;
  logic [15:0]        half_lane;
  logic [NB_DATA-1:0] load_data;

  logic               wb_write_q, wb_mem_to_reg_q, misaligned_q;
  logic [4:0]         write_reg_q;
  logic [NB_DATA-1:0] mem_data_q, alu_result_q;
  logic [NB_DATA-1:0] mem_data_d;
  logic               misaligned_d;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_addr = i_ALU_result[NB_ADDR+1:2];
  assign offset    = i_ALU_result[1:0];
  assign misaligned = is_misaligned(i_mem_size, offset);

  always_comb begin
    byte_we   = 4'b0000;
    wdata     = i_data_to_write_in_MEM;
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (i_mem_size)
      SIZE_BYTE: begin
        byte_we   = 4'b0001 << offset;
        wdata     = {4{i_data_to_write_in_MEM[7:0]}};
        load_data = i_mem_unsigned ? {{(NB_DATA-8){1'b0}}, byte_lane}
                                   : {{(NB_DATA-8){byte_lane[7]}}, byte_lane};
      end
      SIZE_HALF: begin
        byte_we   = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{i_data_to_write_in_MEM[15:0]}};
        load_data = i_mem_unsigned ? {{(NB_DATA-16){1'b0}}, half_lane}
                                   : {{(NB_DATA-16){half_lane[15]}}, half_lane};
      end
      default: begin
        byte_we   = 4'b1111;
      end
    endcase
    // Reset, stall and misalignment all suppress the store.
    if (!i_MEM_write || misaligned || !i_enable || !i_reset) begin
      byte_we = 4'b0000;
    end
    mem_data_d   = (i_MEM_read && !misaligned) ? load_data : '0;
    misaligned_d = misaligned && (i_MEM_read || i_MEM_write);
  end

  data_memory #(
    .NB_DATA  (NB_DATA),
    .MEM_DEPTH(MEM_DEPTH),
    .NB_ADDR  (NB_ADDR)
  ) u_data_memory (
    .i_clk       (i_clk),
    .i_byte_we   (byte_we),
    .i_addr      (word_addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .i_debug_addr(i_debug_addr),
    .o_debug_data(o_debug_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wb_write_q      <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      write_reg_q     <= '0;
      mem_data_q      <= '0;
      alu_result_q    <= '0;
      misaligned_q    <= 1'b0;
    end else if (i_enable) begin
      wb_write_q      <= i_WB_write;
      wb_mem_to_reg_q <= i_WB_mem_to_reg;
      write_reg_q     <= i_write_reg;
      mem_data_q      <= mem_data_d;
      alu_result_q    <= i_ALU_result;
      misaligned_q    <= misaligned_d;
    end
  end

  assign o_WB_write      = wb_write_q;
  assign o_WB_mem_to_reg = wb_mem_to_reg_q;
  assign o_write_reg     = write_reg_q;
  assign o_mem_data      = mem_data_q;
  assign o_ALU_result    = alu_result_q;
  assign o_misaligned    = misaligned_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access against a byte-array reference model.
module tb_memory_access;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable;
  logic        i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned;
  logic [4:0]  i_write_reg;
  logic [31:0] i_ALU_result, i_data_to_write_in_MEM;
  logic [7:0]  i_debug_addr;
  logic        o_WB_write, o_WB_mem_to_reg, o_misaligned;
  logic [4:0]  o_write_reg;
  logic [31:0] o_mem_data, o_ALU_result, o_debug_data;

  memory_access #(
    .NB_DATA  (32),
    .MEM_DEPTH(256),
    .NB_ADDR  (8)
  ) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_enable              (i_enable),
    .i_WB_write            (i_WB_write),
    .i_WB_mem_to_reg       (i_WB_mem_to_reg),
    .i_MEM_read            (i_MEM_read),
    .i_MEM_write           (i_MEM_write),
    .i_mem_size            (i_mem_size),
    .i_mem_unsigned        (i_mem_unsigned),
    .i_write_reg           (i_write_reg),
    .i_ALU_result          (i_ALU_result),
    .i_data_to_write_in_MEM(i_data_to_write_in_MEM),
    .i_debug_addr          (i_debug_addr),
    .o_WB_write            (o_WB_write),
    .o_WB_mem_to_reg       (o_WB_mem_to_reg),
    .o_write_reg           (o_write_reg),
    .o_mem_data            (o_mem_data),
    .o_ALU_result          (o_ALU_result),
    .o_misaligned          (o_misaligned),
    .o_debug_data          (o_debug_data)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: memory as 1024 bytes, plus expected MEM/WB contents.
  logic [7:0]  bytes_m [1024];
  bit          known_m [256];
  logic        e_wb_write, e_mem_to_reg, e_mis;
  logic [4:0]  e_write_reg;
  logic [31:0] e_mem_data, e_alu;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_word(input int unsigned w);
    return {bytes_m[4*w+3], bytes_m[4*w+2], bytes_m[4*w+1], bytes_m[4*w]};
  endfunction

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] alu, input logic [31:0] data,
                        input logic [4:0] wreg, input logic wbw, input logic m2r);
    i_MEM_read = rd;  i_MEM_write = wr;  i_mem_size = size;  i_mem_unsigned = uns;
    i_ALU_result = alu;  i_data_to_write_in_MEM = data;
    i_write_reg = wreg;  i_WB_write = wbw;  i_WB_mem_to_reg = m2r;
  endtask

  // Apply one clock edge, advancing the model from the current inputs, then check.
  task automatic cycle();
    int unsigned a, sz;
    logic [31:0] v;
    logic        mis;
    a  = i_ALU_result & 32'h3FF;
    sz = (i_mem_size == 2'b00) ? 1 : (i_mem_size == 2'b01) ? 2 : 4;
    mis = (a % sz) != 0;
    v = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < sz) v = v | ({24'h0, bytes_m[(a + k) & 1023]} << (8 * k));
    if (sz < 4 && !i_mem_unsigned && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    if (!i_MEM_read || mis) v = 32'h0;
    if (!i_reset) begin
      e_wb_write = 0; e_mem_to_reg = 0; e_mis = 0; e_write_reg = 0;
      e_mem_data = 0; e_alu = 0;
    end else if (i_enable) begin
      e_wb_write = i_WB_write;  e_mem_to_reg = i_WB_mem_to_reg;
      e_write_reg = i_write_reg;  e_alu = i_ALU_result;  e_mem_data = v;
      e_mis = mis && (i_MEM_read || i_MEM_write);
      if (i_MEM_write && !mis) begin
        for (int k = 0; k < 4; k++)
          if (k < sz) bytes_m[a + k] = i_data_to_write_in_MEM[8*k +: 8];
        if (sz == 4) known_m[a / 4] = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    check("wb_write",   {31'h0, o_WB_write},      {31'h0, e_wb_write});
    check("mem_to_reg", {31'h0, o_WB_mem_to_reg}, {31'h0, e_mem_to_reg});
    check("write_reg",  {27'h0, o_write_reg},     {27'h0, e_write_reg});
    check("mem_data",   o_mem_data,               e_mem_data);
    check("alu_result", o_ALU_result,             e_alu);
    check("misaligned", {31'h0, o_misaligned},    {31'h0, e_mis});
    if (known_m[i_debug_addr]) check("debug_data", o_debug_data, model_word(i_debug_addr));
  endtask

  initial begin
    for (int w = 0; w < 256; w++) known_m[w] = 1'b0;
    // Reset with every input non-zero, including a store that must be suppressed.
    i_reset = 0; i_enable = 1; i_debug_addr = 8'h3;
    set_op(1, 1, 2'b10, 1, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 5'd31, 1, 1);
    cycle();
    cycle();
    i_reset = 1;

    // Fill every word with known contents; word 8 starts as zero.
    for (int w = 0; w < 256; w++) begin
      i_debug_addr = w[7:0];
      set_op(0, 1, 2'b10, 0, w * 4, (w == 8) ? 32'h0 : $urandom, 5'd0, 0, 0);
      cycle();
    end

    set_op(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0); cycle();
    set_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd3, 1, 1);         cycle();
    check("lw_deadbeef", o_mem_data, 32'hDEAD_BEEF);

    set_op(0, 1, 2'b00, 0, 32'h21, 32'h1234_5680, 5'd0, 0, 0); cycle();
    set_op(1, 0, 2'b00, 0, 32'h21, 32'h0, 5'd4, 1, 1);         cycle();
    check("lb_sign", o_mem_data, 32'hFFFF_FF80);
    i_debug_addr = 8'd8;
    set_op(1, 0, 2'b00, 1, 32'h21, 32'h0, 5'd4, 1, 1);         cycle();
    check("lbu_zero", o_mem_data, 32'h0000_0080);
    check("word8", o_debug_data, 32'h0000_8000);

    set_op(0, 1, 2'b01, 0, 32'h32, 32'hABCD_1234, 5'd0, 0, 0); cycle();
    set_op(1, 0, 2'b01, 0, 32'h32, 32'h0, 5'd5, 1, 1);         cycle();
    check("lh_1234", o_mem_data, 32'h0000_1234);
    i_debug_addr = 8'h0C;
    set_op(0, 1, 2'b01, 0, 32'h31, 32'h0000_BEEF, 5'd0, 0, 0); cycle();
    check("sh_misaligned", {31'h0, o_misaligned}, 32'h1);

    // Stall: outputs hold and the store is blocked.
    i_debug_addr = 8'h10;
    i_enable = 0;
    set_op(0, 1, 2'b10, 0, 32'h40, 32'hFFFF_FFFF, 5'd9, 1, 0); cycle(); cycle();
    i_enable = 1;
    set_op(1, 0, 2'b10, 0, 32'h40, 32'h0, 5'd9, 1, 1);         cycle();

    set_op(0, 0, 2'b10, 0, 32'h55, 32'h0, 5'd7, 1, 0);         cycle();
    check("rtype_alu", o_ALU_result, 32'h55);
    check("rtype_reg", {27'h0, o_write_reg}, 32'd7);
    check("rtype_mem", o_mem_data, 32'h0);

    // Mid-run reset with a store on the same edge.
    i_reset = 0;
    set_op(1, 1, 2'b10, 1, 32'h40, 32'h1111_1111, 5'd31, 1, 1); cycle();
    i_reset = 1;

    for (int n = 0; n < 400; n++) begin
      i_enable     = ($urandom_range(0, 7) != 0);
      i_reset      = ($urandom_range(0, 49) != 0);
      i_debug_addr = $urandom;
      case ($urandom_range(0, 2))
        0:       set_op(1, 0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1);
        1:       set_op(0, 1, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0);
        default: set_op($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom);
      endcase
      // Narrow the address range sometimes so loads hit recent stores.
      if ($urandom_range(0, 1) == 0) i_ALU_result = i_ALU_result & 32'h0000_001F;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
